// File: rtl/if_stage_fq.sv
// if_stage_fq: instruction fetch stage with a fetch queue between the SRAM and decode.
// Define IF_FQ_BYPASS_EN to let a response reach decode in its arrival cycle while the queue is empty.
module if_stage_fq #(
  parameter int          FQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);
  localparam int AW = $clog2(FQ_DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(FQ_DEPTH);
  logic [63:0]   r_mem [FQ_DEPTH];
  logic [AW-1:0] r_rptr, r_wptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_pc_req, r_rq_pc;
  logic          r_rq_busy;
  logic          w_br_taken, w_issue, w_resp, w_empty, w_byp, w_push, w_pop;
  logic [31:0]   w_br_target;
  logic [AW:0]   w_occ;
  assign w_br_taken  = br_bus[32];
  assign w_br_target = br_bus[31:0];
  // In-flight request counts as occupied so its response always has a slot
  assign w_occ   = r_count + {{AW{1'b0}}, r_rq_busy};
  assign w_issue = resetn && (w_br_taken || w_occ < L_DEPTH);
  assign w_resp  = resetn && r_rq_busy && !w_br_taken;
  assign w_empty = r_count == '0;
`ifdef IF_FQ_BYPASS_EN
  assign w_byp = w_resp && w_empty;
`else
  assign w_byp = 1'b0;
`endif
  assign fs_to_ds_valid  = resetn && !w_br_taken && (!w_empty || w_byp);
  assign fs_to_ds_bus    = w_empty ? {inst_sram_rdata, r_rq_pc} : r_mem[r_rptr];
  assign w_pop           = fs_to_ds_valid && ds_allowin && !w_empty;
  assign w_push          = w_resp && !(w_byp && ds_allowin);
  assign inst_sram_en    = w_issue;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_addr  = w_br_taken ? w_br_target : r_pc_req;
  assign inst_sram_wdata = 32'b0;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rptr    <= '0;
      r_wptr    <= '0;
      r_count   <= '0;
      r_rq_busy <= 1'b0;
      r_pc_req  <= RESET_PC;
      r_rq_pc   <= RESET_PC;
    end else if (w_br_taken) begin
      r_rptr    <= '0;
      r_wptr    <= '0;
      r_count   <= '0;
      r_rq_busy <= 1'b1;
      r_pc_req  <= w_br_target + 32'd4;
      r_rq_pc   <= w_br_target;
    end else begin
      r_rq_busy <= w_issue;
      r_pc_req  <= w_issue ? r_pc_req + 32'd4 : r_pc_req;
      r_rq_pc   <= w_issue ? r_pc_req : r_rq_pc;
      r_wptr    <= w_push ? r_wptr + AW'(1) : r_wptr;
      r_rptr    <= w_pop ? r_rptr + AW'(1) : r_rptr;
      r_count   <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {inst_sram_rdata, r_rq_pc};
  end
endmodule
